bicubic_tile_raster_packer: RTL and testbench
=============================================

// Module: bicubic_tile_raster_packer
// PURPOSE
//  Downstream of the 4x bicubic upsample core. Accepts one 4-pixel beat per response handshake;
//  4 consecutive beats form one 4x4 output tile (beat k = tile row k, data1..4 = columns 0..3).
//  Tiles arrive left-to-right across a 4-row band. Block re-orders them into raster-order
//  4-pixel words via a ping-pong band buffer and feeds them to the output stream.
// PARAMETERS
//  CHANNEL_WIDTH  8     bits per pixel channel
//  OUT_WIDTH      3840  output line width in pixels; multiple of 4, >= 8
//  OUT_HEIGHT     2160  output frame height in lines; multiple of 4, >= 4
// PORTS
//  clk             in   1                clock
//  rst             in   1                synchronous reset, active-high
//  bcci_rsp_valid  in   1                upsample core beat valid
//  bf_rsp_ready    out  1                this block accepts beat
//  bcci_rsp_data1  in   CHANNEL_WIDTH    tile row pixel, column 0
//  bcci_rsp_data2  in   CHANNEL_WIDTH    column 1
//  bcci_rsp_data3  in   CHANNEL_WIDTH    column 2
//  bcci_rsp_data4  in   CHANNEL_WIDTH    column 3
//  out_valid       out  1                raster word valid
//  out_ready       in   1                sink ready
//  out_data        out  4*CHANNEL_WIDTH  {px3,px2,px1,px0}, px0 leftmost, in LSBs
// BEHAVIOUR
//  - One clock; reset synchronous active-high. Reset values: bf_rsp_ready=0 during rst, 1 the
//    cycle after; out_valid=0; out_data=0; all counters 0; both banks empty; wr/rd bank = 0.
//  - Handshakes: in_hsk = bcci_rsp_valid & bf_rsp_ready; out_hsk = out_valid & out_ready.
//    out_valid, once high, stays high with out_data stable until out_hsk.
//  - Storage: 2 banks x (4*OUT_WIDTH/4) words of 4*CHANNEL_WIDTH; addr = row*(OUT_WIDTH/4)+tile.
//  - Write side: counters wr_row (0..3), wr_tile (0..OUT_WIDTH/4-1), wr_bank. Each in_hsk writes
//    addr(wr_row,wr_tile) of wr_bank, wr_row++; on wr_row 3 wraps, wr_tile++. On last beat of band
//    (row 3, last tile): set full[wr_bank], toggle wr_bank, zero counters.
//  - bf_rsp_ready = ~rst_q & ~full[wr_bank]; both banks full -> ready low (backpressure to core).
//  - Read side: counters rd_row, rd_tile, rd_bank. When full[rd_bank], read raster order:
//    rd_tile inner, rd_row outer. Synchronous-read RAM + output register: first out_valid of a
//    band no earlier than 2 cycles after full set; sustained 1 word/clk while out_ready=1.
//    Single-entry prefetch/skid so a stall never drops or duplicates a word.
//  - Last word of band (row 3, last tile) out_hsk: clear full[rd_bank], toggle rd_bank.
//  - Simultaneous set of full[wr_bank] and clear of full[rd_bank] (different banks) both take
//    effect same cycle. Bank freed this cycle may be written next cycle, not same cycle.
//  - Band counter rd_band counts 0..OUT_HEIGHT/4-1, wraps at frame end; no inter-frame gap needed.
//  - Reset mid-band: buffered data discarded, no further out_valid until a new full band arrives.
//  - Data path is pure reordering: no arithmetic, bit-exact pass-through of input pixels.
// CONFIGURATION
//  BCCI_PACK_LINE_FLAGS_EN defined: adds outputs out_sol (1b), out_eol (1b), out_sof (1b),
//    qualified by out_valid: sol on rd_tile==0, eol on rd_tile==last, sof on first word of
//    rd_band 0 row 0. Flags registered with out_data, identical stall behaviour.
//  Undefined: ports absent, band counter logic removed; data/handshake behaviour identical.
// TESTING (OUT_WIDTH=8, OUT_HEIGHT=8)
//  1 Reset: rst=1 3 clks -> out_valid=0, out_data=0, bf_rsp_ready=0; rst=0 -> ready=1 next clk.
//  2 Band reorder: 8 beats, tile t row r data=(16t+4r+{0,1,2,3}), out_ready=1 -> out words in
//    order rows 0..3, tile 0 then 1: first {03,02,01,00}, second {13,12,11,10}, 8 words total.
//  3 Backpressure: out_ready=0, feed 16 beats (2 bands) -> bf_rsp_ready drops after 16th beat,
//    17th beat not accepted; out_ready=1 -> 16 words in order, ready returns after band 0 drains.
//  4 Random stalls: random valid/out_ready 50% for 4 bands -> output equals golden raster, no
//    dup/drop; out_data stable while out_valid & ~out_ready.
//  5 Reset mid-band: 5 beats then rst 1 clk -> no out_valid; fresh 8-beat band output correct.
//  6 Flags (macro on): 2 bands -> sol on words 0,2,4..; eol on 1,3,5..; sof only on word 0
//    of band 0, again on first word after 2 bands (frame wrap).

Source files
------------

// File: rtl/bicubic_tile_raster_packer_if.sv
// Bundles the packer's bus signals: the beat stream from the 4x bicubic
// upsample core and the raster word stream to the sink.
// Port summary:
//   bcci_rsp_valid / bf_rsp_ready        beat handshake (core -> packer)
//   bcci_rsp_data1..4                    tile row pixels, columns 0..3
//   out_valid / out_ready                raster word handshake (packer -> sink)
//   out_data                             {px3,px2,px1,px0}, px0 in the LSBs
//   out_sol / out_eol / out_sof          line/frame flags, only when
//                                        BCCI_PACK_LINE_FLAGS_EN is defined
// The slave modport is the packer; the master modport is its environment
// (core on the input side, sink on the output side).
interface bicubic_tile_raster_packer_if #(
  parameter int unsigned CHANNEL_WIDTH = 8
);
  logic                         bcci_rsp_valid;
  logic                         bf_rsp_ready;
  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data1;
  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data2;
  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data3;
  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data4;
  logic                         out_valid;
  logic                         out_ready;
  logic [4*CHANNEL_WIDTH-1:0]   out_data;
`ifdef BCCI_PACK_LINE_FLAGS_EN
  logic                         out_sol;
  logic                         out_eol;
  logic                         out_sof;
`endif

  modport slave (
    input  bcci_rsp_valid,
    output bf_rsp_ready,
    input  bcci_rsp_data1,
    input  bcci_rsp_data2,
    input  bcci_rsp_data3,
    input  bcci_rsp_data4,
    output out_valid,
    input  out_ready,
`ifdef BCCI_PACK_LINE_FLAGS_EN
    output out_sol,
    output out_eol,
    output out_sof,
`endif
    output out_data
  );

  modport master (
    output bcci_rsp_valid,
    input  bf_rsp_ready,
    output bcci_rsp_data1,
    output bcci_rsp_data2,
    output bcci_rsp_data3,
    output bcci_rsp_data4,
    input  out_valid,
    output out_ready,
`ifdef BCCI_PACK_LINE_FLAGS_EN
    input  out_sol,
    input  out_eol,
    input  out_sof,
`endif
    input  out_data
  );
endinterface

// File: rtl/bicubic_tile_raster_packer.sv
// Re-orders 4x4 tiles from the bicubic upsample core into raster-order
// 4-pixel words through a ping-pong band buffer (two banks of one 4-row band).
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   bicubic_tile_raster_packer_if.slave (beat input, raster word output)
// Optional feature macro: BCCI_PACK_LINE_FLAGS_EN adds out_sol/out_eol/out_sof
// flags carried alongside out_data, plus the band counter that drives sof.
module bicubic_tile_raster_packer #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned OUT_WIDTH     = 3840,
  parameter int unsigned OUT_HEIGHT    = 2160
) (
  input  logic clk,
  input  logic rst,
  bicubic_tile_raster_packer_if.slave bus
);

  localparam int unsigned DW  = 4 * CHANNEL_WIDTH;   // raster word width
  localparam int unsigned TPL = OUT_WIDTH / 4;       // tiles per band row
  localparam int unsigned NW  = 4 * TPL;             // words per bank
  localparam int unsigned MW  = $clog2(2 * NW);      // memory index width
  localparam int unsigned TW  = $clog2(TPL);         // tile counter width
`ifdef BCCI_PACK_LINE_FLAGS_EN
  localparam int unsigned GW  = 4;                   // tag: {sof,eol,sol,last}
  localparam int unsigned NB  = OUT_HEIGHT / 4;      // bands per frame
  localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
`else
  localparam int unsigned GW  = 1;                   // tag: {last}
`endif
  localparam int unsigned PW  = DW + GW;             // payload = {tag, data}

  // Elaboration guard against unsupported geometry.
  if ((OUT_WIDTH % 4) != 0 || OUT_WIDTH < 8 ||
      (OUT_HEIGHT % 4) != 0 || OUT_HEIGHT < 4) begin : g_bad_geometry
    $error("bicubic_tile_raster_packer: unsupported OUT_WIDTH/OUT_HEIGHT");
  end

  // State
  logic            r_rst_q;
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic [1:0]      r_wr_row;
  logic [TW-1:0]   r_wr_tile;
  logic            r_rd_bank;
  logic [1:0]      r_rd_row;
  logic [TW-1:0]   r_rd_tile;
  logic            r_iss_done;
  logic            r_ram_vld;
  logic [GW-1:0]   r_ram_tag;
  logic [DW-1:0]   r_ram_dout;
  logic            r_skid_vld;
  logic [PW-1:0]   r_skid_pay;
  logic            r_out_vld;
  logic [PW-1:0]   r_out_pay;
  logic [DW-1:0]   r_mem [2*NW];
`ifdef BCCI_PACK_LINE_FLAGS_EN
  logic [BW-1:0]   r_rd_band;
`endif

  // Combinational
  logic            w_ready;
  logic            w_in_hsk;
  logic            w_out_hsk;
  logic            w_wr_last;
  logic [DW-1:0]   w_wr_data;
  logic [MW-1:0]   w_wr_addr;
  logic [MW-1:0]   w_wr_idx;
  logic            w_rd_last;
  logic [MW-1:0]   w_rd_addr;
  logic [MW-1:0]   w_rd_idx;
  logic [1:0]      w_occ;
  logic            w_room;
  logic            w_rd_en;
  logic [GW-1:0]   w_rd_tag;
  logic            w_out_last;
  logic [PW-1:0]   w_ram_pay;
  logic [1:0]      w_full_n;
  logic            w_out_vld_n;
  logic [PW-1:0]   w_out_pay_n;
  logic            w_skid_vld_n;
  logic [PW-1:0]   w_skid_pay_n;

  // Handshakes; ready is held low through reset and for one cycle after.
  assign w_ready   = ~r_rst_q & ~r_full[r_wr_bank];
  assign w_in_hsk  = bus.bcci_rsp_valid & w_ready;
  assign w_out_hsk = r_out_vld & bus.out_ready;

  assign bus.bf_rsp_ready = w_ready;
  assign bus.out_valid    = r_out_vld;
  assign bus.out_data     = r_out_pay[DW-1:0];
`ifdef BCCI_PACK_LINE_FLAGS_EN
  assign bus.out_sol      = r_out_pay[DW+1];
  assign bus.out_eol      = r_out_pay[DW+2];
  assign bus.out_sof      = r_out_pay[DW+3];
`endif

  // Write addressing: column 0 of the tile row lands in the word LSBs.
  assign w_wr_data = {bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                      bus.bcci_rsp_data2, bus.bcci_rsp_data1};
  assign w_wr_last = (r_wr_row == 2'd3) && (r_wr_tile == TW'(TPL - 1));
  assign w_wr_addr = MW'(r_wr_row) * MW'(TPL) + MW'(r_wr_tile);
  assign w_wr_idx  = r_wr_bank ? (w_wr_addr + MW'(NW)) : w_wr_addr;

  // Read addressing in raster order (tile inner, row outer).
  assign w_rd_last = (r_rd_row == 2'd3) && (r_rd_tile == TW'(TPL - 1));
  assign w_rd_addr = MW'(r_rd_row) * MW'(TPL) + MW'(r_rd_tile);
  assign w_rd_idx  = r_rd_bank ? (w_rd_addr + MW'(NW)) : w_rd_addr;

  // Issue a RAM read only when the word is guaranteed a slot (output reg or
  // skid) on arrival, counting what the sink drains this cycle.
  assign w_occ   = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_ram_vld) - 2'(w_out_hsk);
  assign w_room  = (w_occ < 2'd2);
  assign w_rd_en = r_full[r_rd_bank] & ~r_iss_done & w_room;

`ifdef BCCI_PACK_LINE_FLAGS_EN
  assign w_rd_tag = {(r_rd_band == '0) && (r_rd_row == 2'd0) && (r_rd_tile == '0),
                     (r_rd_tile == TW'(TPL - 1)),
                     (r_rd_tile == '0),
                     w_rd_last};
`else
  assign w_rd_tag = w_rd_last;
`endif

  assign w_out_last = r_out_pay[DW];
  assign w_ram_pay  = {r_ram_tag, r_ram_dout};

  // Full flags: set by the writer, cleared by the reader; always different banks.
  always_comb begin
    w_full_n = r_full;
    if (w_in_hsk && w_wr_last) w_full_n[r_wr_bank] = 1'b1;
    if (w_out_hsk && w_out_last) w_full_n[r_rd_bank] = 1'b0;
  end

  // Output register / skid steering, oldest word first: out, skid, RAM.
  always_comb begin
    w_out_vld_n  = r_out_vld;
    w_out_pay_n  = r_out_pay;
    w_skid_vld_n = r_skid_vld;
    w_skid_pay_n = r_skid_pay;
    if (!r_out_vld || w_out_hsk) begin
      if (r_skid_vld) begin
        w_out_vld_n  = 1'b1;
        w_out_pay_n  = r_skid_pay;
        w_skid_vld_n = r_ram_vld;
        if (r_ram_vld) w_skid_pay_n = w_ram_pay;
      end else if (r_ram_vld) begin
        w_out_vld_n  = 1'b1;
        w_out_pay_n  = w_ram_pay;
      end else begin
        w_out_vld_n  = 1'b0;
      end
    end else if (r_ram_vld) begin
      w_skid_vld_n = 1'b1;
      w_skid_pay_n = w_ram_pay;
    end
  end

  // Delayed reset for ready gating.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  // Band buffer storage (not reset; contents are qualified by r_full).
  always_ff @(posedge clk) begin
    if (w_in_hsk) r_mem[w_wr_idx] <= w_wr_data;
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    if (w_rd_en) r_ram_dout <= r_mem[w_rd_idx];
  end

  // Write-side counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_row  <= 2'd0;
      r_wr_tile <= '0;
    end else if (w_in_hsk) begin
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_row  <= 2'd0;
        r_wr_tile <= '0;
      end else begin
        r_wr_row <= r_wr_row + 2'd1;
        if (r_wr_row == 2'd3) r_wr_tile <= r_wr_tile + TW'(1);
      end
    end
  end

  // Read-side counters; the bank only flips once its last word has left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= 2'b00;
      r_rd_bank  <= 1'b0;
      r_rd_row   <= 2'd0;
      r_rd_tile  <= '0;
      r_iss_done <= 1'b0;
    end else begin
      r_full <= w_full_n;
      if (w_rd_en) begin
        if (w_rd_last) begin
          r_iss_done <= 1'b1;
          r_rd_row   <= 2'd0;
          r_rd_tile  <= '0;
        end else if (r_rd_tile == TW'(TPL - 1)) begin
          r_rd_tile <= '0;
          r_rd_row  <= r_rd_row + 2'd1;
        end else begin
          r_rd_tile <= r_rd_tile + TW'(1);
        end
      end
      if (w_out_hsk && w_out_last) begin
        r_rd_bank  <= ~r_rd_bank;
        r_iss_done <= 1'b0;
      end
    end
  end

`ifdef BCCI_PACK_LINE_FLAGS_EN
  // Band index within the frame, advanced as each band finishes draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_band <= '0;
    end else if (w_out_hsk && w_out_last) begin
      r_rd_band <= (r_rd_band == BW'(NB - 1)) ? '0 : r_rd_band + BW'(1);
    end
  end
`endif

  // Read pipeline: RAM stage, skid entry and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_vld  <= 1'b0;
      r_ram_tag  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_pay <= '0;
      r_out_vld  <= 1'b0;
      r_out_pay  <= '0;
    end else begin
      r_ram_vld  <= w_rd_en;
      if (w_rd_en) r_ram_tag <= w_rd_tag;
      r_skid_vld <= w_skid_vld_n;
      r_skid_pay <= w_skid_pay_n;
      r_out_vld  <= w_out_vld_n;
      r_out_pay  <= w_out_pay_n;
    end
  end

endmodule

// File: tb/tb_bicubic_tile_raster_packer.sv
// Directed + randomized bench for bicubic_tile_raster_packer with an 8x8
// frame (2 tiles per line, 2 bands per frame). A reference model collects
// accepted beats, and on each completed band pushes the raster-order words
// (and line/frame flags when BCCI_PACK_LINE_FLAGS_EN is defined) to a queue
// that is popped on every output handshake.
module tb_bicubic_tile_raster_packer;

  localparam int unsigned CW  = 8;
  localparam int unsigned OW  = 8;
  localparam int unsigned OH  = 8;
  localparam int unsigned TPL = OW / 4;
  localparam int unsigned NB  = OH / 4;
  localparam int unsigned BB  = 4 * TPL;   // beats per band

  typedef struct packed {
    logic [4*CW-1:0] data;
    logic            sol;
    logic            eol;
    logic            sof;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic fixed_ready;
  logic rand_mode;
  logic rnd_ready;

  int vectors     = 0;
  int miscompares = 0;
  int out_words   = 0;

  exp_t            exp_q[$];
  logic [4*CW-1:0] beats[BB];
  int              nbeat;
  int              band_idx;
  logic            hold_pend;
  logic [4*CW-1:0] hold_data;

  bicubic_tile_raster_packer_if #(.CHANNEL_WIDTH(CW)) bus ();

  bicubic_tile_raster_packer #(
    .CHANNEL_WIDTH(CW),
    .OUT_WIDTH    (OW),
    .OUT_HEIGHT   (OH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = rand_mode ? rnd_ready : fixed_ready;

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  // Model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      nbeat     = 0;
      band_idx  = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        vectors++;
        assert (bus.out_valid === 1'b1 && bus.out_data === hold_data) else begin
          miscompares++;
          $error("FAIL stall_hold observed valid=%b data=%h expected valid=1 data=%h",
                 bus.out_valid, bus.out_data, hold_data);
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;

      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_word observed data=%h expected no word", bus.out_data);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          out_words++;
          vectors++;
          assert (bus.out_data === e.data) else begin
            miscompares++;
            $error("FAIL word_data observed %h expected %h", bus.out_data, e.data);
          end
`ifdef BCCI_PACK_LINE_FLAGS_EN
          vectors++;
          assert ({bus.out_sol, bus.out_eol, bus.out_sof} === {e.sol, e.eol, e.sof}) else begin
            miscompares++;
            $error("FAIL flags observed sol/eol/sof=%b expected %b",
                   {bus.out_sol, bus.out_eol, bus.out_sof}, {e.sol, e.eol, e.sof});
          end
`endif
        end
      end

      if (bus.bcci_rsp_valid && bus.bf_rsp_ready) begin
        beats[nbeat] = {bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                        bus.bcci_rsp_data2, bus.bcci_rsp_data1};
        nbeat++;
        if (nbeat == int'(BB)) begin
          for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < int'(TPL); t++) begin
              exp_t e;
              e.data = beats[t*4 + r];
              e.sol  = (t == 0);
              e.eol  = (t == int'(TPL) - 1);
              e.sof  = (band_idx == 0) && (r == 0) && (t == 0);
              exp_q.push_back(e);
            end
          end
          nbeat    = 0;
          band_idx = (band_idx + 1) % int'(NB);
        end
      end
    end
  end

  function automatic logic [4*CW-1:0] pat(input int t, input int r, input int base);
    logic [7:0] p0, p1, p2, p3;
    p0 = 8'(base + 16*t + 4*r + 0);
    p1 = 8'(base + 16*t + 4*r + 1);
    p2 = 8'(base + 16*t + 4*r + 2);
    p3 = 8'(base + 16*t + 4*r + 3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic send_beat(input logic [4*CW-1:0] w, input int gap);
    logic acc;
    acc = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.bcci_rsp_valid = 1'b1;
    bus.bcci_rsp_data1 = w[7:0];
    bus.bcci_rsp_data2 = w[15:8];
    bus.bcci_rsp_data3 = w[23:16];
    bus.bcci_rsp_data4 = w[31:24];
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (bus.bf_rsp_ready) acc = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    vectors++;
    assert (acc) else begin
      miscompares++;
      $error("FAIL beat_accept observed accepted=%b expected 1 (data %h)", acc, w);
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end
    bus.bcci_rsp_valid = 1'b0;
  endtask

  task automatic send_band(input int base);
    for (int t = 0; t < int'(TPL); t++)
      for (int r = 0; r < 4; r++)
        send_beat(pat(t, r, base), 0);
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL drain_%s observed pending=%0d expected 0", tag, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    rst                = 1'b1;
    fixed_ready        = 1'b0;
    rand_mode          = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    bus.bcci_rsp_data1 = '0;
    bus.bcci_rsp_data2 = '0;
    bus.bcci_rsp_data3 = '0;
    bus.bcci_rsp_data4 = '0;

    // 1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    assert (bus.out_valid === 1'b0) else begin
      miscompares++; $error("FAIL rst_out_valid observed %b expected 0", bus.out_valid);
    end
    vectors++;
    assert (bus.out_data === 32'h0) else begin
      miscompares++; $error("FAIL rst_out_data observed %h expected 0", bus.out_data);
    end
    vectors++;
    assert (bus.bf_rsp_ready === 1'b0) else begin
      miscompares++; $error("FAIL rst_ready observed %b expected 0", bus.bf_rsp_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    assert (bus.bf_rsp_ready === 1'b0) else begin
      miscompares++; $error("FAIL ready_release_cycle observed %b expected 0", bus.bf_rsp_ready);
    end
    @(negedge clk);
    vectors++;
    assert (bus.bf_rsp_ready === 1'b1) else begin
      miscompares++; $error("FAIL ready_after_rst observed %b expected 1", bus.bf_rsp_ready);
    end
    @(posedge clk);
    #1;

    // 2: single band reorder
    w0 = out_words;
    send_band(0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    vectors++;
    assert (bus.out_valid === 1'b1 && bus.out_data === 32'h03020100) else begin
      miscompares++;
      $error("FAIL first_word observed valid=%b data=%h expected 1/03020100",
             bus.out_valid, bus.out_data);
    end
    @(posedge clk);
    #1;
    fixed_ready = 1'b1;
    drain("band");
    vectors++;
    assert (out_words - w0 == int'(BB)) else begin
      miscompares++; $error("FAIL band_words observed %0d expected %0d", out_words - w0, BB);
    end

    // 3: backpressure with both banks full
    fixed_ready = 1'b0;
    send_band(8'h80);
    send_band(8'h40);
    @(negedge clk);
    vectors++;
    assert (bus.bf_rsp_ready === 1'b0) else begin
      miscompares++; $error("FAIL bp_ready observed %b expected 0", bus.bf_rsp_ready);
    end
    vectors++;
    assert (bus.out_valid === 1'b1 && bus.out_data === pat(0, 0, 8'h80)) else begin
      miscompares++;
      $error("FAIL bp_head observed valid=%b data=%h expected 1/%h",
             bus.out_valid, bus.out_data, pat(0, 0, 8'h80));
    end
    @(posedge clk);
    #1;
    bus.bcci_rsp_valid = 1'b1;
    bus.bcci_rsp_data1 = 8'hEE;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      assert (bus.bf_rsp_ready === 1'b0) else begin
        miscompares++; $error("FAIL beat17_blocked observed ready=%b expected 0", bus.bf_rsp_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.bcci_rsp_valid = 1'b0;
    w0 = out_words;
    fixed_ready = 1'b1;
    drain("bp");
    vectors++;
    assert (out_words - w0 == 2 * int'(BB)) else begin
      miscompares++; $error("FAIL bp_words observed %0d expected %0d", out_words - w0, 2 * BB);
    end
    @(negedge clk);
    vectors++;
    assert (bus.bf_rsp_ready === 1'b1) else begin
      miscompares++; $error("FAIL bp_ready_return observed %b expected 1", bus.bf_rsp_ready);
    end
    @(posedge clk);
    #1;

    // 4: random valid gaps and random sink stalls, 4 bands
    rand_mode = 1'b1;
    w0 = out_words;
    for (int i = 0; i < 4 * int'(BB); i++)
      send_beat($urandom, int'($urandom_range(0, 1)));
    drain("rand");
    vectors++;
    assert (out_words - w0 == 4 * int'(BB)) else begin
      miscompares++; $error("FAIL rand_words observed %0d expected %0d", out_words - w0, 4 * BB);
    end
    rand_mode   = 1'b0;
    fixed_ready = 1'b1;

    // 5: reset in the middle of a band
    for (int i = 0; i < 5; i++) send_beat(pat(i / 4, i % 4, 8'h20), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      assert (bus.out_valid === 1'b0) else begin
        miscompares++; $error("FAIL midrst_quiet observed out_valid=%b expected 0", bus.out_valid);
      end
    end
    @(posedge clk);
    #1;
    w0 = out_words;
    send_band(8'h60);
    drain("midrst");
    vectors++;
    assert (out_words - w0 == int'(BB)) else begin
      miscompares++; $error("FAIL midrst_words observed %0d expected %0d", out_words - w0, BB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
